// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan decoder.
//   seg_t     : 7-bit active-low segment bus, bit6=a ... bit0=g
//   SEG_0..9  : legal digit patterns (active-low)
//   SEG_BLANK : all segments off
//   BCD_NONE  : code reported for blank or illegal patterns
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_NONE = 4'hF;

endpackage

// File: rtl/seg_to_bcd.sv
// seg_to_bcd: combinational decode of one active-low segment pattern.
//   seg   in  7  segment pattern (active-low)
//   code  out 4  BCD digit, BCD_NONE for blank or illegal patterns
//   blank out 1  pattern is all segments off
//   err   out 1  pattern is neither a digit nor blank
module seg_to_bcd
  import seg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  always_comb begin
    code  = BCD_NONE;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a multiplexed active-low 7-segment bus.
// A digit is accepted once {an_i, seg_i} has been identical for
// STABLE_CYCLES cycles with exactly one anode low; when every slot has
// been accepted the whole frame is published with a one-cycle pulse.
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   seg_i          in   7   segment bus, active-low, bit6=a .. bit0=g
//   an_i           in   N_DIGITS anode enables, active-low
//   digits_o       out  4*N_DIGITS BCD per slot, slot k in [4k+3:4k]
//   blank_o        out  N_DIGITS slot was blank
//   err_o          out  N_DIGITS slot showed an illegal pattern
//   frame_valid_o  out  one-cycle pulse when the outputs update
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  seg_t                  seg_i,
  input  logic [N_DIGITS-1:0]   an_i,
  output logic [4*N_DIGITS-1:0] digits_o,
  output logic [N_DIGITS-1:0]   blank_o,
  output logic [N_DIGITS-1:0]   err_o,
  output logic                  frame_valid_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic {COLLECT, PUBLISH} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(STABLE_CYCLES)) ? c : c + 1'b1;
  endfunction

  logic [N_DIGITS-1:0] an_p1;
  seg_t                seg_p1;
  logic [CNT_W-1:0]    cnt_p1;

  logic                an_ok, same, cap;
  logic [IDX_W-1:0]    idx;
  logic [N_DIGITS-1:0] cap_bits;
  logic [3:0]          dec_code;
  logic                dec_blank, dec_err;

  logic [3:0]          sh_code [N_DIGITS];
  logic [N_DIGITS-1:0] sh_blank, sh_err;
  logic [N_DIGITS-1:0] seen_mask, mask_nxt;
  logic [4*N_DIGITS-1:0] digits_nxt;
  logic [N_DIGITS-1:0] blank_nxt, err_nxt;
  state_t              state;

  assign an_ok = $onehot(~an_i);
  assign same  = an_ok && (an_i == an_p1) && (seg_i == seg_p1);
  // The compare against STABLE_CYCLES-2 fires on the STABLE_CYCLES-th
  // identical cycle, and only once because the counter moves past it.
  assign cap   = same && (cnt_p1 == CNT_W'(STABLE_CYCLES - 2));

  // ---- stage p1: stability tracker ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= '1;
      seg_p1 <= SEG_BLANK;
      cnt_p1 <= '0;
    end else begin
      an_p1  <= an_i;
      seg_p1 <= seg_i;
      cnt_p1 <= same ? sat_inc(cnt_p1) : '0;
    end
  end

  // During a capture the registered value equals the live one.
  always_comb begin
    idx = '0;
    for (int k = 0; k < N_DIGITS; k++)
      if (!an_p1[k]) idx = IDX_W'(k);
  end

  assign cap_bits = cap ? ~an_p1 : '0;
  assign mask_nxt = seen_mask | cap_bits;

  seg_to_bcd u_dec (
    .seg   (seg_p1),
    .code  (dec_code),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // ---- stage p2: per-slot shadows ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_DIGITS; k++) sh_code[k] <= '0;
      sh_blank <= '0;
      sh_err   <= '0;
    end else if (cap) begin
      sh_code[idx]  <= dec_code;
      sh_blank[idx] <= dec_blank;
      sh_err[idx]   <= dec_err;
    end
  end

  // Frame contents including a capture landing on this same edge, so the
  // completing digit is published without an extra cycle of latency.
  always_comb begin
    digits_nxt = '0;
    blank_nxt  = '0;
    err_nxt    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (cap && (idx == IDX_W'(k))) begin
        digits_nxt[4*k +: 4] = dec_code;
        blank_nxt[k]         = dec_blank;
        err_nxt[k]           = dec_err;
      end else begin
        digits_nxt[4*k +: 4] = sh_code[k];
        blank_nxt[k]         = sh_blank[k];
        err_nxt[k]           = sh_err[k];
      end
    end
  end

  // ---- stage p3: frame FSM and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      seen_mask     <= '0;
      digits_o      <= '0;
      blank_o       <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          frame_valid_o <= 1'b0;
          if (&mask_nxt) begin
            digits_o      <= digits_nxt;
            blank_o       <= blank_nxt;
            err_o         <= err_nxt;
            frame_valid_o <= 1'b1;
            seen_mask     <= '0;
            state         <= PUBLISH;
          end else begin
            seen_mask <= mask_nxt;
          end
        end
        PUBLISH: begin
          // A capture here belongs to the next frame.
          frame_valid_o <= 1'b0;
          seen_mask     <= cap_bits;
          state         <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  import seg_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  seg_t           seg_i;
  logic [N-1:0]   an_i;
  logic [4*N-1:0] digits_o;
  logic [N-1:0]   blank_o, err_o;
  logic           frame_valid_o;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  logic prev_fv = 1'b0;

  seg_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_i         (seg_i),
    .an_i          (an_i),
    .digits_o      (digits_o),
    .blank_o       (blank_o),
    .err_o         (err_o),
    .frame_valid_o (frame_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called just after a negedge; holds the slot for n rising edges.
  task automatic show(input int slot, input seg_t pat, input int n);
    an_i  = ~(4'b0001 << slot);
    seg_i = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an_i = 4'b1111;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
    exp_q.push_back('{digits: d, blank: b, err: e});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_digits"}, 32'(digits_o), 32'h0);
    check({tag, "_blank"}, 32'(blank_o), 32'h0);
    check({tag, "_err"}, 32'(err_o), 32'h0);
    check({tag, "_fv"}, 32'(frame_valid_o), 32'h0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid_o) begin
        n_frames++;
        check("fv_not_consecutive", 32'(prev_fv), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(digits_o), 32'hFFFF_FFFF);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          check("frame_digits", 32'(digits_o), 32'(f.digits));
          check("frame_blank", 32'(blank_o), 32'(f.blank));
          check("frame_err", 32'(err_o), 32'(f.err));
        end
      end
      prev_fv = frame_valid_o;
    end else begin
      prev_fv = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0;
    an_i  = 4'b1111;
    seg_i = SEG_BLANK;
    #2;
    check_outputs_zero("reset_initial");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Normal frame 1,2,3,4
    show(0, SEG_1, 8);
    show(1, SEG_2, 8);
    show(2, SEG_3, 8);
    expect_frame(16'h4321, 4'b0000, 4'b0000);
    show(3, SEG_4, 8);
    idle(4);

    // Glitch rejection: 7-cycle run on slot 2 must not complete the frame
    show(0, SEG_7, 8);
    show(1, SEG_8, 8);
    show(3, SEG_0, 8);
    show(2, SEG_2, 7);
    idle(10);
    expect_frame(16'h0687, 4'b0000, 4'b0000);
    show(2, SEG_6, 8);
    idle(4);

    // Blank and illegal patterns
    show(0, SEG_9, 8);
    show(1, SEG_BLANK, 8);
    show(2, SEG_5, 8);
    expect_frame(16'hF5F9, 4'b0010, 4'b1000);
    show(3, 7'b1010101, 8);
    idle(4);

    // Invalid anodes: counter stays cleared
    an_i  = 4'b1111;
    seg_i = SEG_3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) check("cnt_an_none", 32'(dut.cnt_p1), 32'h0);
    end
    an_i = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) check("cnt_an_multi", 32'(dut.cnt_p1), 32'h0);
    end
    check("hold_after_invalid", 32'(digits_o), 32'hF5F9);

    // Overwrite: slot 0 shows 5 then 9, latest wins
    show(0, SEG_5, 8);
    show(0, SEG_9, 8);
    show(1, SEG_0, 8);
    show(2, SEG_1, 8);
    expect_frame(16'h2109, 4'b0000, 4'b0000);
    show(3, SEG_2, 8);
    idle(4);

    // Reset after two slots captured
    show(0, SEG_3, 8);
    show(1, SEG_4, 8);
    an_i  = 4'b1010;
    seg_i = 7'b0110011;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs_zero("reset_release");
    show(2, SEG_7, 8);
    show(3, SEG_8, 8);
    idle(4);
    check_outputs_zero("reset_partial");
    show(0, SEG_1, 8);
    expect_frame(16'h8711, 4'b0000, 4'b0000);
    show(1, SEG_1, 8);
    idle(5);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("frame_count", 32'(n_frames), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
